// File: rtl/sc_mac_datapath.sv
// Stochastic-computing multiply-accumulate datapath.
// An AND gate multiplies two stochastic vectors. A 2:1 select then picks either
// the product or an addend vector. A registered accumulator adds the number of
// ones in the selected vector to a binary count on every enabled cycle.
module sc_mac_datapath #(
    parameter int WIDTH = 16,
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    input  logic [WIDTH-1:0] add_b,
    input  logic             add_sel,
    input  logic             acc_en,
    output logic [WIDTH-1:0] prod_out,
    output logic [WIDTH-1:0] sum_vec,
    output logic [ACC_W-1:0] bin_out,
    output logic             acc_ovf
);

    // Popcount range is 0..WIDTH inclusive, so one extra value beyond 2^n-1 may be needed.
    localparam int PC_W = $clog2(WIDTH + 1);

    logic [PC_W-1:0]  pc;
    logic [ACC_W:0]   acc_sum;

    // Multiply stage: the AND of two independent streams has density p_a * p_b.
    always_comb begin
        prod_out = mul_a & mul_b;
    end

    // Scaled-add stage: a single select applies to the whole vector, not per bit.
    always_comb begin
        sum_vec = add_sel ? add_b : prod_out;
    end

    // Count the ones in the selected vector.
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + PC_W'(sum_vec[i]);
        end
    end

    // Accumulator adder. The extra top bit is the carry out of ACC_W bits.
    always_comb begin
        acc_sum = {1'b0, bin_out} + (ACC_W + 1)'(pc);
    end

    // Accumulator register. The count wraps modulo 2^ACC_W, and the wrap flag stays set until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out <= '0;
            acc_ovf <= 1'b0;
        end else if (acc_en) begin
            bin_out <= acc_sum[ACC_W-1:0];
            acc_ovf <= acc_ovf | acc_sum[ACC_W];
        end
    end

endmodule

// File: tb/tb_sc_mac_datapath.sv
// Self-checking bench for sc_mac_datapath.
// The model keeps the total number of ones accumulated since reset as a plain integer.
// From that total it derives the expected bin_out (total mod 256) and acc_ovf (total >= 256).
module tb_sc_mac_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mul_a   = '0;
    logic [15:0] mul_b   = '0;
    logic [15:0] add_b   = '0;
    logic        add_sel = 1'b0;
    logic        acc_en  = 1'b0;
    logic [15:0] prod_out;
    logic [15:0] sum_vec;
    logic [7:0]  bin_out;
    logic        acc_ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int total = 0;
    int dens [16] = '{1, 2, 3, 4, 3, 2, 1, 2, 3, 4, 5, 6, 7, 3, 2, 1};

    sc_mac_datapath #(.WIDTH(16), .ACC_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .add_b    (add_b),
        .add_sel  (add_sel),
        .acc_en   (acc_en),
        .prod_out (prod_out),
        .sum_vec  (sum_vec),
        .bin_out  (bin_out),
        .acc_ovf  (acc_ovf)
    );

    always #5 clk = ~clk;

    // Model: total ones accumulated since the last reset.
    always @(posedge clk or posedge rst) begin
        if (rst)
            total = 0;
        else if (acc_en)
            total = total + $countones(add_sel ? add_b : (mul_a & mul_b));
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model, away from both clock edges.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            check("prod_out", int'(prod_out), int'(mul_a & mul_b));
            check("sum_vec", int'(sum_vec), int'(add_sel ? add_b : (mul_a & mul_b)));
            check("bin_out", int'(bin_out), total % 256);
            check("acc_ovf", int'(acc_ovf), int'(total >= 256));
        end
    end

    // Apply one vector, let one rising edge pass, and return just after the falling edge.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ab,
                        input logic sel, input logic en);
        mul_a   = a;
        mul_b   = b;
        add_b   = ab;
        add_sel = sel;
        acc_en  = en;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] addend_vec(input int t);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = (t < dens[i]);
        return v;
    endfunction

    task automatic product_run();
        logic [15:0] b;
        b = 16'h0003;
        for (int t = 0; t < 16; t++) begin
            step(16'h001F, b, 16'h0000, 1'b0, 1'b1);
            b = {b[14:0], b[15]};
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int held;

        // Reset: arbitrary inputs with accumulate enabled; outputs must stay at zero.
        rst = 1'b1;
        mul_a = 16'hA5C3; mul_b = 16'hFFFF; add_b = 16'h1234; add_sel = 1'b0; acc_en = 1'b1;
        @(negedge clk);
        #1;
        check("reset_bin", int'(bin_out), 0);
        check("reset_ovf", int'(acc_ovf), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold_bin", int'(bin_out), 0);
        check("reset_hold_ovf", int'(acc_ovf), 0);
        @(negedge clk);
        rst = 1'b0;

        // Product MAC: the rotations of mul_b give 5 * 2 = 10 ones in total.
        product_run();
        #1;
        check("product_mac_bin", int'(bin_out), 8'h0A);
        check("product_mac_ovf", int'(acc_ovf), 0);

        // Full MAC: the addend streams contribute 49 ones, giving 59.
        for (int t = 0; t < 16; t++) step(16'h001F, 16'h0003, addend_vec(t), 1'b1, 1'b1);
        #1;
        check("full_mac_bin", int'(bin_out), 8'h3B);

        // Enable hold: an all-ones vector with accumulate disabled must leave bin_out unchanged.
        held = int'(bin_out);
        for (int t = 0; t < 5; t++) step(16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0);
        #1;
        check("hold_bin", int'(bin_out), 59);
        step(16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
        #1;
        check("hold_then_add", int'(bin_out), held + 16);

        // Wrap: 17 all-ones cycles from zero.
        pulse_reset();
        for (int t = 0; t < 15; t++) step(16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
        #1;
        check("wrap_pre_ovf", int'(acc_ovf), 0);
        check("wrap_pre_bin", int'(bin_out), 8'hF0);
        step(16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
        #1;
        check("wrap_16_ovf", int'(acc_ovf), 1);
        check("wrap_16_bin", int'(bin_out), 8'h00);
        step(16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1);
        #1;
        check("wrap_17_bin", int'(bin_out), 8'h10);
        check("wrap_17_ovf", int'(acc_ovf), 1);

        // Async reset in the middle of the addend phase, between clock edges.
        pulse_reset();
        product_run();
        for (int t = 0; t < 7; t++) step(16'h001F, 16'h0003, addend_vec(t), 1'b1, 1'b1);
        #1;
        check("mid_run_nonzero", int'(bin_out != 0), 1);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_bin", int'(bin_out), 0);
        check("async_rst_ovf", int'(acc_ovf), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        product_run();
        #1;
        check("after_rst_mac", int'(bin_out), 8'h0A);

        @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
